// File: rtl/hazard_detect_unit.sv
// Decode-side hazard detector: tracks destinations in flight (EX/MEM/WB) and
// raises an execute bubble (dhazard) and a fetch/decode freeze (stall).
module hazard_detect_unit #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      id_ins,
    input  logic             flush,
    output logic             dhazard,
    output logic             stall,
    output logic [7:0]       busy_regs,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LOAD   = 4'h4;
    localparam logic [3:0] OP_STORE  = 4'h5;
    localparam logic [3:0] OP_BRANCH = 4'hC;

    typedef struct packed {
        logic       valid;
        logic [2:0] rd;
        logic       is_load;
    } sb_entry_t;

    sb_entry_t        ex_q, mem_q, wb_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [3:0] op;
    logic [2:0] rs1, rs2, rd;
    logic       uses_rs1, uses_rs2, has_dst, is_load;
    logic       raw_ex, raw_mem, raw_wb, hz;

    // Function bits [2:0] carry no register fields for hazard purposes.
    logic unused_funct;
    assign unused_funct = &{1'b0, id_ins[2:0]};

    function automatic logic raw(input sb_entry_t e, input logic [2:0] r1, input logic [2:0] r2,
                                 input logic u1, input logic u2);
        return e.valid && ((u1 && (e.rd == r1)) || (u2 && (e.rd == r2)));
    endfunction

    always_comb begin
        op       = id_ins[15:12];
        rs1      = id_ins[11:9];
        rs2      = id_ins[8:6];
        rd       = id_ins[5:3];
        uses_rs1 = (op != OP_NOP);
        uses_rs2 = (op != OP_NOP) && (op != OP_LOAD);
        has_dst  = (op != OP_NOP) && (op != OP_STORE) && (op != OP_BRANCH);
        is_load  = (op == OP_LOAD);
    end

    assign raw_ex  = raw(ex_q,  rs1, rs2, uses_rs1, uses_rs2);
    assign raw_mem = raw(mem_q, rs1, rs2, uses_rs1, uses_rs2);
    assign raw_wb  = raw(wb_q,  rs1, rs2, uses_rs1, uses_rs2);

    // With forwarding only a load still in EX is too late for the consumer.
    assign hz      = FWD_EN ? (raw_ex && ex_q.is_load) : (raw_ex || raw_mem || raw_wb);
    assign stall   = hz && !flush;
    assign dhazard = hz || flush;

    always_comb begin
        ex_d = '0;
        if (!dhazard) begin
            ex_d.valid   = has_dst;
            ex_d.rd      = rd;
            ex_d.is_load = is_load && has_dst;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // NOTE: non-blocking assignments make the EX->MEM->WB shift use the
    // pre-edge values of every stage, exactly like the real pipeline registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        busy_regs = '0;
        if (ex_q.valid)  busy_regs[ex_q.rd]  = 1'b1;
        if (mem_q.valid) busy_regs[mem_q.rd] = 1'b1;
        if (wb_q.valid)  busy_regs[wb_q.rd]  = 1'b1;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Bench for hazard_detect_unit: three instances (forwarding, no forwarding,
// 4-bit counter) share stimulus; a history-of-issued-words model checks all.
module tb_hazard_detect_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [15:0] id_ins;

    logic [2:0]  dh_o, st_o;
    logic [7:0]  busy_o [3];
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_detect_unit #(.FWD_EN(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .id_ins(id_ins), .flush(flush),
        .dhazard(dh_o[0]), .stall(st_o[0]), .busy_regs(busy_o[0]), .stall_cnt(cnt0));
    hazard_detect_unit #(.FWD_EN(1'b0), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .id_ins(id_ins), .flush(flush),
        .dhazard(dh_o[1]), .stall(st_o[1]), .busy_regs(busy_o[1]), .stall_cnt(cnt1));
    hazard_detect_unit #(.FWD_EN(1'b0), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .id_ins(id_ins), .flush(flush),
        .dhazard(dh_o[2]), .stall(st_o[2]), .busy_regs(busy_o[2]), .stall_cnt(cnt2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the last three words that entered EX (bubble = 16'h0), newest first.
    logic [15:0] hist [3][3];
    int unsigned mcnt [3];
    int unsigned mmax [3] = '{65535, 65535, 15};
    bit          exp_st [3];
    bit          exp_dh [3];
    bit          model_on = 1'b0;

    function automatic bit writes(input logic [15:0] w);
        logic [3:0] op = w[15:12];
        return (op != 4'h0) && (op != 4'h5) && (op != 4'hC);
    endfunction

    function automatic bit reads(input logic [15:0] w, input logic [2:0] r);
        logic [3:0] op = w[15:12];
        return (op != 4'h0) && ((w[11:9] == r) || ((op != 4'h4) && (w[8:6] == r)));
    endfunction

    task automatic model_check();
        for (int d = 0; d < 3; d++) begin
            bit          hz = 1'b0;
            logic [7:0]  eb = '0;
            logic [31:0] a_cnt;
            for (int k = 0; k < 3; k++) begin
                if (writes(hist[d][k])) begin
                    eb[hist[d][k][5:3]] = 1'b1;
                    if (reads(id_ins, hist[d][k][5:3])) begin
                        if (d != 0) hz = 1'b1;
                        else if (k == 0 && hist[d][k][15:12] == 4'h4) hz = 1'b1;
                    end
                end
            end
            exp_st[d] = hz && !flush;
            exp_dh[d] = hz || flush;
            case (d)
                0:       a_cnt = 32'(cnt0);
                1:       a_cnt = 32'(cnt1);
                default: a_cnt = 32'(cnt2);
            endcase
            check($sformatf("m%0d stall", d),   32'(st_o[d]),   32'(exp_st[d]));
            check($sformatf("m%0d dhazard", d), 32'(dh_o[d]),   32'(exp_dh[d]));
            check($sformatf("m%0d busy", d),    32'(busy_o[d]), 32'(eb));
            check($sformatf("m%0d cnt", d),     a_cnt,          mcnt[d]);
        end
    endtask

    task automatic model_update();
        for (int d = 0; d < 3; d++) begin
            if (!reset) begin
                for (int k = 0; k < 3; k++) hist[d][k] = '0;
                mcnt[d] = 0;
            end else begin
                hist[d][2] = hist[d][1];
                hist[d][1] = hist[d][0];
                hist[d][0] = exp_dh[d] ? 16'h0000 : id_ins;
                if (exp_st[d] && mcnt[d] < mmax[d]) mcnt[d]++;
            end
        end
        if (!reset) model_on = 1'b1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        if (model_on) model_check();
    endtask

    task automatic at_pos();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cycle();
        at_neg();
        at_pos();
    endtask

    task automatic do_reset();
        reset = 1'b0; id_ins = 16'h0000; flush = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
    endtask

    typedef struct {
        logic [15:0] ins;
        logic        fl;
        logic        est;
        logic        edh;
        logic [7:0]  ebusy;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // Directed vectors for the forwarding instance, applied back to back.
        tbl[0]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0}; // reset state
        tbl[1]  = '{16'h4010, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0}; // LOAD R2
        tbl[2]  = '{16'h1400, 1'b0, 1'b1, 1'b1, 8'h04, 16'd0}; // load-use
        tbl[3]  = '{16'h1400, 1'b0, 1'b0, 1'b0, 8'h04, 16'd1}; // issues after 1 bubble
        tbl[4]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 8'h05, 16'd1}; // ADD R0 in EX, LOAD in WB
        tbl[5]  = '{16'h4010, 1'b0, 1'b0, 1'b0, 8'h01, 16'd1};
        tbl[6]  = '{16'h1400, 1'b1, 1'b0, 1'b1, 8'h05, 16'd1}; // flush beats hazard
        tbl[7]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 8'h04, 16'd1}; // EX was bubbled
        tbl[8]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 8'h04, 16'd1};
        tbl[9]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1};
        tbl[10] = '{16'h1018, 1'b1, 1'b0, 1'b1, 8'h00, 16'd1}; // plain flush
        tbl[11] = '{16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1}; // flushed ALU never entered
        tbl[12] = '{16'h4000, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1}; // LOAD R0
        tbl[13] = '{16'h1000, 1'b0, 1'b1, 1'b1, 8'h01, 16'd1}; // R0 is an ordinary reg
        tbl[14] = '{16'h1000, 1'b0, 1'b0, 1'b0, 8'h01, 16'd2};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            id_ins = tbl[i].ins;
            flush  = tbl[i].fl;
            at_neg();
            check($sformatf("t%0d stall", i),   32'(st_o[0]),   32'(tbl[i].est));
            check($sformatf("t%0d dhazard", i), 32'(dh_o[0]),   32'(tbl[i].edh));
            check($sformatf("t%0d busy", i),    32'(busy_o[0]), 32'(tbl[i].ebusy));
            check($sformatf("t%0d cnt", i),     32'(cnt0),      32'(tbl[i].ecnt));
            at_pos();
        end

        // No forwarding: producer immediately ahead costs three stall cycles.
        do_reset();
        id_ins = 16'h1018; cycle();
        id_ins = 16'h10C0;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            check($sformatf("nf c%0d stall", c), 32'(st_o[1]), (c < 3) ? 32'd1 : 32'd0);
            check($sformatf("nf c%0d cnt", c),   32'(cnt1),    32'(c));
            if (c == 0) check("nf busy", 32'(busy_o[1]), 32'h08);
            at_pos();
        end

        // Reset during the second stall cycle clears everything on the next edge.
        do_reset();
        id_ins = 16'h1018; cycle();
        id_ins = 16'h10C0; cycle();
        reset = 1'b0; cycle();
        reset = 1'b1;
        at_neg();
        check("rst busy",  32'(busy_o[1]), 32'h00);
        check("rst stall", 32'(st_o[1]),   32'd0);
        check("rst cnt",   32'(cnt1),      32'd0);
        at_pos();

        // Self-dependent ALU stream keeps hazards coming; 4-bit counter must saturate.
        do_reset();
        id_ins = 16'h1208;
        for (int c = 0; c < 40; c++) cycle();
        at_neg();
        check("sat cnt", 32'(cnt2), 32'h0F);
        at_pos();

        // Random traffic on a narrow register set to make hazards frequent.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 1) == 0) begin
                id_ins = {4'($urandom_range(0, 15)), 3'($urandom_range(0, 3)),
                          3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                          3'($urandom_range(0, 7))};
            end
            flush = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 59) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
